// File: rtl/ar_shift_seq_pkg.sv
// Shared types and default sizes for the ALU result register (AR) stage.
// Contents: command and state encodings, default register and counter widths.
// Imported by the interface, the shift core and the sequencer top.
package ar_pkg;

  localparam int AR_WIDTH = 36;  // nine 4-bit ALU slices
  localparam int AR_CNT_W = 6;   // step counter width

  // Encoding matches the 2-bit cmd bus: 00 HOLD, 01 LOAD, 10 SHL, 11 SHR.
  typedef enum logic [1:0] {
    AR_HOLD = 2'b00,
    AR_LOAD = 2'b01,
    AR_SHL  = 2'b10,
    AR_SHR  = 2'b11
  } ar_cmd_e;

  typedef enum logic [1:0] {
    AR_IDLE = 2'b00,
    AR_RUN  = 2'b01,
    AR_DONE = 2'b10
  } ar_state_e;

  // True for the two shift commands, which are the only ones that can run counted.
  function automatic logic ar_is_shift(input ar_cmd_e c);
    return (c == AR_SHL) || (c == AR_SHR);
  endfunction

endpackage

// File: rtl/ar_shift_seq_if.sv
// Bundle of the AR stage datapath and control signals (bit 0 is the MSB).
// Inputs: alu_f, alu_cout, cmd, start, step_count, abort, ser_in_l, ser_in_r.
// Outputs: q, link, busy, done. master = driver side, slave = the AR stage.
interface ar_shift_seq_if #(
  parameter int WIDTH = ar_pkg::AR_WIDTH,
  parameter int CNT_W = ar_pkg::AR_CNT_W
);

  logic [0:WIDTH-1] alu_f;
  logic             alu_cout;
  logic [0:1]       cmd;
  logic             start;
  logic [0:CNT_W-1] step_count;
  logic             abort;
  logic             ser_in_l;
  logic             ser_in_r;
  logic [0:WIDTH-1] q;
  logic             link;
  logic             busy;
  logic             done;

  modport master (
    output alu_f, alu_cout, cmd, start, step_count, abort, ser_in_l, ser_in_r,
    input  q, link, busy, done
  );

  modport slave (
    input  alu_f, alu_cout, cmd, start, step_count, abort, ser_in_l, ser_in_r,
    output q, link, busy, done
  );

endinterface

// File: rtl/ar_shift_seq_core.sv
// Combinational next-state for the AR register: HOLD, LOAD, SHL or SHR.
// Ports: q_i/link_i current value, op_i operation, alu_f_i/alu_cout_i load data,
//        ser_in_l_i/ser_in_r_i fill bits; q_o/link_o next value.
module ar_shift_core
  import ar_pkg::*;
#(
  parameter int WIDTH = AR_WIDTH
) (
  input  logic [0:WIDTH-1] q_i,
  input  logic             link_i,
  input  ar_cmd_e          op_i,
  input  logic [0:WIDTH-1] alu_f_i,
  input  logic             alu_cout_i,
  input  logic             ser_in_l_i,
  input  logic             ser_in_r_i,
  output logic [0:WIDTH-1] q_o,
  output logic             link_o
);

  always_comb begin
    q_o    = q_i;
    link_o = link_i;
    case (op_i)
      AR_LOAD: begin
        q_o    = alu_f_i;
        link_o = alu_cout_i;
      end
      // Left = towards bit 0 (MSB); the bit leaving bit 0 lands in link.
      AR_SHL: begin
        link_o = q_i[0];
        q_o    = {q_i[1:WIDTH-1], ser_in_r_i};
      end
      AR_SHR: begin
        link_o = q_i[WIDTH-1];
        q_o    = {ser_in_l_i, q_i[0:WIDTH-2]};
      end
      default: begin
        q_o    = q_i;
        link_o = link_i;
      end
    endcase
  end

endmodule

// File: rtl/ar_shift_seq.sv
// AR result register: captures the ALU F bus/carry and runs single or counted shifts.
// Ports: clk, rst_n (async, active low), bus (slave side of ar_shift_seq_if).
// A counted sequence started at edge k shifts on edges k+1..k+N, then pulses done.
module ar_shift_seq
  import ar_pkg::*;
#(
  parameter int WIDTH = AR_WIDTH,
  parameter int CNT_W = AR_CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  ar_shift_seq_if.slave bus
);

  ar_state_e        state_q;
  ar_cmd_e          op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [0:WIDTH-1] q_q;
  logic [0:WIDTH-1] q_d;
  logic             link_q;
  logic             link_d;
  logic             busy_q;
  logic             done_q;
  ar_cmd_e          cmd_e;
  ar_cmd_e          op_sel;
  logic [CNT_W-1:0] step_n;

  assign cmd_e  = ar_cmd_e'(bus.cmd);
  assign step_n = bus.step_count;

  // Operation applied to the register at the coming edge. A counted shift does
  // not move on its start edge, and abort freezes the register in both states.
  always_comb begin
    op_sel = AR_HOLD;
    case (state_q)
      AR_IDLE: if (!bus.abort && (!bus.start || !ar_is_shift(cmd_e))) op_sel = cmd_e;
      AR_RUN:  if (!bus.abort) op_sel = op_q;
      default: op_sel = AR_HOLD;
    endcase
  end

  ar_shift_core #(.WIDTH(WIDTH)) u_core (
    .q_i        (q_q),
    .link_i     (link_q),
    .op_i       (op_sel),
    .alu_f_i    (bus.alu_f),
    .alu_cout_i (bus.alu_cout),
    .ser_in_l_i (bus.ser_in_l),
    .ser_in_r_i (bus.ser_in_r),
    .q_o        (q_d),
    .link_o     (link_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= AR_IDLE;
      op_q    <= AR_HOLD;
      cnt_q   <= '0;
      q_q     <= '0;
      link_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      link_q <= link_d;
      done_q <= 1'b0;
      case (state_q)
        AR_IDLE: begin
          if (!bus.abort && bus.start) begin
            if (ar_is_shift(cmd_e) && (step_n != '0)) begin
              state_q <= AR_RUN;
              op_q    <= cmd_e;
              cnt_q   <= step_n;
              busy_q  <= 1'b1;
            end else begin
              state_q <= AR_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        AR_RUN: begin
          if (bus.abort) begin
            state_q <= AR_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            // cnt==1 means this edge performs the final shift.
            if (cnt_q == CNT_W'(1)) begin
              state_q <= AR_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= AR_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q    = q_q;
  assign bus.link = link_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/ar_shift_seq.md
Name: ar_shift_seq

Overview:
- Result register stage directly downstream of the ALU slice chain: nine cascaded 4-bit ALU slices give a 36-bit F bus plus a ripple carry-out.
- Captures F and carry-out, holds them, and performs single or counted multi-step left/right shifts with serial fill.
- Its output q returns to the A inputs of the ALU slices, so multiply and divide step sequences iterate through it.
- Bit numbering is DEC order: bit 0 is the MSB.

Parameters:
- WIDTH, 36, register width (nine 4-bit slices).
- CNT_W, 6, width of the step counter; one sequence runs at most 2^CNT_W-1 steps.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alu_f  in  [0:WIDTH-1]  ALU F bus.
- alu_cout  in  1  carry-out of the most significant ALU slice.
- cmd  in  [0:1]  operation: 00 HOLD, 01 LOAD, 10 SHL, 11 SHR.
- start  in  1  begin a counted sequence using cmd and step_count.
- step_count  in  [0:CNT_W-1]  number of shift steps for the sequence.
- abort  in  1  terminate a running sequence.
- ser_in_l  in  1  fill bit entering bit 0 on SHR.
- ser_in_r  in  1  fill bit entering bit WIDTH-1 on SHL.
- q  out  [0:WIDTH-1]  register contents.
- link  out  1  carry/shift-out flag.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous on rst_n low): q=0, link=0, cnt=0, state=IDLE, busy=0, done=0. Reset mid-sequence abandons the sequence; no done pulse.
- Operation effects, applied at the clock edge:
  - HOLD: no change.
  - LOAD: q<=alu_f, link<=alu_cout.
  - SHL: link<=q[0]; q[0:WIDTH-2]<=q[1:WIDTH-1]; q[WIDTH-1]<=ser_in_r.
  - SHR: link<=q[WIDTH-1]; q[1:WIDTH-1]<=q[0:WIDTH-2]; q[0]<=ser_in_l.
- State machine: IDLE, RUN, DONE. All outputs are registered; busy=(state==RUN); done=(state==DONE).
- IDLE:
  - abort=1: no effect; abort takes priority over start.
  - start=0: apply cmd as a single operation at this edge; stay in IDLE; latency 1 cycle.
  - start=1 with cmd HOLD or LOAD: apply the operation; go to DONE.
  - start=1 with cmd SHL or SHR and step_count=0: no shift; go to DONE.
  - start=1 with cmd SHL or SHR and step_count=N>0: latch the op; cnt<=N; go to RUN. No shift occurs on the start edge.
- RUN:
  - cmd, start and step_count are ignored.
  - abort=1: go to IDLE; no shift at this edge; no done pulse.
  - Otherwise: perform the latched shift; cnt<=cnt-1. If cnt==1, go to DONE.
- DONE: lasts exactly one cycle, then IDLE unconditionally. start, cmd and abort are ignored in DONE.
- Sequence timing: start sampled at edge k gives shifts at edges k+1..k+N, busy high for N cycles, and done high between edges k+N and k+N+1.
- No arithmetic is performed; link is purely a captured bit.
- A counter wrap below 0 is unreachable by construction.

Decomposition:
- ar_pkg holds:
  - cmd encoding enum (AR_HOLD, AR_LOAD, AR_SHL, AR_SHR);
  - state enum (AR_IDLE, AR_RUN, AR_DONE);
  - localparam defaults for WIDTH and CNT_W.
- One combinational sub-module, ar_shift_core: inputs q, link, op, alu_f, alu_cout, ser_in_l and ser_in_r; outputs the next q and next link. Shared by the IDLE single-op path and the RUN path.
- The sequencer FSM and counter stay in ar_shift_seq.

Test Plan:
- Reset: drive rst_n low mid-clock with arbitrary inputs -> immediately q=0, link=0, busy=0, done=0. Release; apply cmd=HOLD for 3 cycles -> q stays 0.
- LOAD: alu_f=0o123456701234, alu_cout=1, cmd=LOAD, start=0 -> after 1 edge q=0o123456701234, link=1, done stays 0.
- Single SHL: q=0o400000000000, ser_in_r=1, cmd=SHL, start=0 -> q=0o000000000001, link=1.
- Counted SHR:
  - Stimulus: q=0o000000000017, ser_in_l=0, start=1, cmd=SHR, step_count=3.
  - Response: busy high for 3 cycles; q=0o000000000001, link=1; done high for exactly 1 cycle after the third shift; then IDLE.
- Zero count: start=1, cmd=SHL, step_count=0 -> no shift, busy never high, done high on the next cycle, q unchanged.
- Abort:
  - Stimulus: q=0o000000000017, start SHR with step_count=5; assert abort after 2 shifts.
  - Response: q=0o000000000003 and held; busy drops next edge; done never asserts.
  - Repeat with rst_n asserted mid-run -> all outputs go to reset values.
